mem_arb: RTL

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb_if.sv | 56 +++++
 rtl/mem_arb.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mem_arb_if.sv
// Bus bundle for mem_arb: fetch port, load/store port, memory port and the
// timeout error pulse. The master modport is the arbiter's view; the slave
// modport is the view of the surrounding requesters and memory.
interface mem_arb_if #(
    parameter int unsigned XLEN = 64
);
    // Fetch port
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic            if_gnt;
    logic            if_rvalid;
    logic [XLEN-1:0] if_rdata;

    // Load/store port
    logic            ls_req;
    logic            ls_we;
    logic [XLEN-1:0] ls_addr;
    logic [XLEN-1:0] ls_wdata;
    logic [7:0]      ls_wmask;
    logic            ls_gnt;
    logic            ls_rvalid;
    logic [XLEN-1:0] ls_rdata;

    // Memory port
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [7:0]      mem_wmask;
    logic            mem_ready;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    // Timeout abort pulse
    logic            err;

    modport master (
        input  if_req, if_addr,
        input  ls_req, ls_we, ls_addr, ls_wdata, ls_wmask,
        input  mem_ready, mem_rvalid, mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output ls_gnt, ls_rvalid, ls_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        output err
    );

    modport slave (
        output if_req, if_addr,
        output ls_req, ls_we, ls_addr, ls_wdata, ls_wmask,
        output mem_ready, mem_rvalid, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  err
    );
endinterface

// File: rtl/mem_arb.sv
// mem_arb: two-port (fetch, load/store) arbiter onto a single memory port,
// one transaction in flight, with a response timeout that aborts the
// transaction and pulses err.
// Optional feature macro MEM_ARB_RR_EN: when defined, simultaneous requests
// alternate between the ports (round-robin); when undefined, load/store
// always wins a tie.
module mem_arb #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input logic       clk,
    input logic       rst,
    mem_arb_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;
    typedef enum logic {OWN_IF, OWN_LS} owner_t;

    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    state_t          state_q, state_d;
    owner_t          owner_q, owner_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [7:0]      wmask_q, wmask_d;
    logic [7:0]      cnt_q, cnt_d;

    logic            take_ls;
    logic            rsp_fire;
    logic [XLEN-1:0] rsp_data;

`ifdef MEM_ARB_RR_EN
    owner_t          last_q, last_d;
`endif

    // State, owner, latched request fields and RESP wait counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= OWN_IF;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef MEM_ARB_RR_EN
    // Port granted most recently, used to break ties
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= OWN_IF;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // Arbitration, next-state and all bus outputs
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        cnt_d   = cnt_q;
`ifdef MEM_ARB_RR_EN
        last_d  = last_q;
`endif
        take_ls  = 1'b0;
        rsp_fire = 1'b0;
        rsp_data = '0;

        bus.if_gnt    = 1'b0;
        bus.ls_gnt    = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wmask = '0;
        bus.err       = 1'b0;

`ifdef MEM_ARB_RR_EN
        take_ls = bus.ls_req && (!bus.if_req || (last_q == OWN_IF));
`else
        take_ls = bus.ls_req;
`endif

        unique case (state_q)
            S_IDLE: begin
                // Grant is combinational but suppressed while reset is held
                if (!rst && (bus.if_req || bus.ls_req)) begin
                    state_d = S_REQ;
                    if (take_ls) begin
                        bus.ls_gnt = 1'b1;
                        owner_d    = OWN_LS;
                        we_d       = bus.ls_we;
                        addr_d     = bus.ls_addr;
                        // Non-store transactions carry zero write data/mask
                        wdata_d    = bus.ls_we ? bus.ls_wdata : '0;
                        wmask_d    = bus.ls_we ? bus.ls_wmask : '0;
                    end else begin
                        bus.if_gnt = 1'b1;
                        owner_d    = OWN_IF;
                        we_d       = 1'b0;
                        addr_d     = bus.if_addr;
                        wdata_d    = '0;
                        wmask_d    = '0;
                    end
`ifdef MEM_ARB_RR_EN
                    last_d = take_ls ? OWN_LS : OWN_IF;
`endif
                end
            end
            S_REQ: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = we_q;
                // Reads are doubleword aligned; stores pass the address through
                bus.mem_addr  = we_q ? addr_q : {addr_q[XLEN-1:3], 3'b000};
                bus.mem_wdata = wdata_q;
                bus.mem_wmask = wmask_q;
                if (bus.mem_ready) begin
                    state_d = S_RESP;
                    cnt_d   = '0;
                end
            end
            S_RESP: begin
                // A real response beats a timeout landing in the same cycle
                if (bus.mem_rvalid) begin
                    rsp_fire = 1'b1;
                    rsp_data = bus.mem_rdata;
                    state_d  = S_IDLE;
                end else if (cnt_q == TO_CNT) begin
                    rsp_fire = 1'b1;
                    bus.err  = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        bus.if_rvalid = rsp_fire && (owner_q == OWN_IF);
        bus.ls_rvalid = rsp_fire && (owner_q == OWN_LS);
        bus.if_rdata  = (rsp_fire && (owner_q == OWN_IF)) ? rsp_data : '0;
        bus.ls_rdata  = (rsp_fire && (owner_q == OWN_LS)) ? rsp_data : '0;
    end
endmodule
